whack_game_controller: RTL and testbench

- Top-level sequencer for the whack-a-mole game.
- Runs the start countdown, then chooses a pseudo-random hole to raise a mole in each round and times how long the mole stays up.
- Checks player whacks against the active hole, owns the score register, and ends the game when the game timer expires.
- Sits between the debounced button/switch inputs and the display/LED drivers. Time is paced by an external tick strobe.

---
 rtl/whack_game_controller.sv | 198 +++++++++++++++++++
 tb/tb_whack_game_controller.sv | 548 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/whack_game_controller.sv
// Whack-a-mole sequencer: start countdown, pseudo-random mole spawn,
// hit/penalty/miss scoring and the game timer, paced by an external tick.
// Ports: clk, rst (async, active-high), tick, start_btn, whack[NUM_HOLES]
// in; mole[NUM_HOLES], score[8], time_left[8], hit_pulse, game_over,
// state[3] out. All outputs are registered.
module whack_game_controller #(
  parameter int unsigned NUM_HOLES   = 8,
  parameter int unsigned GAME_TICKS  = 60,
  parameter int unsigned MOLE_TICKS  = 2,
  parameter int unsigned START_TICKS = 3,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start_btn,
  input  logic [NUM_HOLES-1:0] whack,
  output logic [NUM_HOLES-1:0] mole,
  output logic [7:0]           score,
  output logic [7:0]           time_left,
  output logic                 hit_pulse,
  output logic                 game_over,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd1,
    S_SPAWN  = 3'd2,
    S_ACTIVE = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [7:0] GT   = 8'(GAME_TICKS);
  localparam logic [7:0] STK  = 8'(START_TICKS);
  localparam logic [3:0] MT   = 4'(MOLE_TICKS);
  localparam logic [7:0] NH8  = 8'(NUM_HOLES);
  localparam logic [2:0] NHM1 = 3'(NUM_HOLES - 1);
  localparam logic [NUM_HOLES-1:0] ONE =
    {{(NUM_HOLES-1){1'b0}}, 1'b1};

  state_t st, st_n;

  logic                 start_q, start_r;
  logic [NUM_HOLES-1:0] whack_q, whack_r;
  logic [7:0]           lfsr;
  logic                 lfsr_fb;

  logic [2:0]           prev_hole, prev_n;
  logic [2:0]           hole_raw, hole;
  logic [3:0]           mtimer, mtimer_n;
  logic [NUM_HOLES-1:0] mole_n;
  logic [7:0]           score_n, tl_n;
  logic [7:0]           score_inc, score_dec;
  logic                 hit_n, hit, wrong;

  // Rises are registered so the FSM always sees a clean
  // one-cycle strobe: pin-to-score latency is two cycles.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      start_r <= 1'b0;
      whack_q <= '0;
      whack_r <= '0;
      lfsr    <= LFSR_SEED;
    end else begin
      start_q <= start_btn;
      start_r <= start_btn & ~start_q;
      whack_q <= whack;
      whack_r <= whack & ~whack_q;
      lfsr    <= {lfsr[6:0], lfsr_fb};
    end
  end

  // Never raise the same hole twice in a row.
  assign hole_raw = 3'(lfsr % NH8);

  always_comb begin
    hole = hole_raw;
    if (hole_raw == prev_hole) begin
      hole = (hole_raw == NHM1) ? 3'd0 : hole_raw + 3'd1;
    end
  end

  assign hit   = |(whack_r & mole);
  assign wrong = (|whack_r) & ~hit;

  assign score_inc = (score == 8'hFF) ? score : score + 8'd1;
  assign score_dec = (score == 8'h00) ? score : score - 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      mole      <= '0;
      score     <= '0;
      time_left <= '0;
      hit_pulse <= 1'b0;
      game_over <= 1'b0;
      prev_hole <= '0;
      mtimer    <= '0;
    end else begin
      st        <= st_n;
      mole      <= mole_n;
      score     <= score_n;
      time_left <= tl_n;
      hit_pulse <= hit_n;
      game_over <= (st_n == S_OVER);
      prev_hole <= prev_n;
      mtimer    <= mtimer_n;
    end
  end

  always_comb begin
    st_n     = st;
    mole_n   = mole;
    score_n  = score;
    tl_n     = time_left;
    prev_n   = prev_hole;
    mtimer_n = mtimer;
    hit_n    = 1'b0;
    unique case (st)
      S_IDLE: begin
        mole_n = '0;
        if (start_r) begin
          st_n    = S_COUNT;
          score_n = '0;
          tl_n    = STK;
        end
      end
      S_COUNT: begin
        mole_n = '0;
        if (tick) begin
          if (time_left == 8'd1) begin
            st_n = S_SPAWN;
            tl_n = GT;
          end else begin
            tl_n = time_left - 8'd1;
          end
        end
      end
      S_SPAWN: begin
        mole_n   = ONE << hole;
        prev_n   = hole;
        mtimer_n = MT;
        st_n     = S_ACTIVE;
        if (tick) begin
          tl_n = time_left - 8'd1;
          // Game ran out before the mole came up.
          if (time_left == 8'd1) begin
            mole_n = '0;
            prev_n = prev_hole;
            st_n   = S_OVER;
          end
        end
      end
      S_ACTIVE: begin
        if (hit) begin
          score_n = score_inc;
          hit_n   = 1'b1;
          mole_n  = '0;
          st_n    = S_SPAWN;
        end else if (wrong) begin
          score_n = score_dec;
        end
        if (tick) begin
          mtimer_n = mtimer - 4'd1;
          if (mtimer == 4'd1) begin
            mole_n = '0;
            st_n   = S_SPAWN;
          end
          // Game end overrides hit and miss exits.
          tl_n = time_left - 8'd1;
          if (time_left == 8'd1) begin
            mole_n = '0;
            st_n   = S_OVER;
          end
        end
      end
      S_OVER: begin
        mole_n = '0;
        if (start_r) begin
          st_n    = S_COUNT;
          score_n = '0;
          tl_n    = STK;
        end
      end
      default: begin
        st_n   = S_IDLE;
        mole_n = '0;
      end
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_whack_game_controller.sv
// Bench for whack_game_controller: directed scenarios plus randomized
// games checked against a transaction-level score/timer model.
module tb_whack_game_controller;

  localparam int NH  = 8;
  localparam int GT  = 5;
  localparam int MT  = 2;
  localparam int STK = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          start_btn;
  logic [NH-1:0] whack;
  logic [NH-1:0] mole;
  logic [7:0]    score;
  logic [7:0]    time_left;
  logic          hit_pulse;
  logic          game_over;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  int            m_score;
  int            m_game;
  int            m_mole;
  logic [NH-1:0] prev_mole;
  bit            prev_known;

  whack_game_controller #(
    .NUM_HOLES(NH),
    .GAME_TICKS(GT),
    .MOLE_TICKS(MT),
    .START_TICKS(STK),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .start_btn(start_btn),
    .whack(whack),
    .mole(mole),
    .score(score),
    .time_left(time_left),
    .hit_pulse(hit_pulse),
    .game_over(game_over),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  function automatic logic [NH-1:0] wrong_bit(input logic [NH-1:0] m);
    int h;
    int r;
    logic [NH-1:0] v;
    h = 0;
    for (int i = 0; i < NH; i++) if (m[i]) h = i;
    r = $urandom_range(0, NH - 2);
    if (r >= h) r++;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  function automatic bit fresh_mole(input logic [NH-1:0] m);
    return $onehot(m) && (!prev_known || m !== prev_mole);
  endfunction

  function automatic int sat_inc(input int s);
    return (s >= 255) ? 255 : s + 1;
  endfunction

  function automatic int floor_dec(input int s);
    return (s <= 0) ? 0 : s - 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick = 1'b0;
    start_btn = 1'b0;
    whack = '0;
    #12;
    checks++;
    if ({state, mole, score, time_left, hit_pulse, game_over} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d mole=%b score=%0d tl=%0d hit=%b over=%b, want all 0",
               state, mole, score, time_left, hit_pulse, game_over);
    end
    rst = 1'b0;
    step();
    pulse_tick();
    step();
    checks++;
    if (state !== 3'd0 || time_left !== 8'd0) begin
      errors++;
      $display("FAIL idle_tick: state=%0d tl=%0d, want 0/0", state, time_left);
    end
    prev_mole = 'b1;
    prev_known = 1'b1;
  endtask

  task automatic test_countdown();
    pulse_start();
    checks++;
    if (state !== 3'd1 || time_left !== 8'(STK) || score !== 8'd0) begin
      errors++;
      $display("FAIL countdown_start: state=%0d tl=%0d score=%0d, want 1/%0d/0",
               state, time_left, score, STK);
    end
    for (int k = 1; k <= STK; k++) begin
      if (k == 1) whack = wrong_bit(8'b1);
      pulse_tick();
      whack = '0;
      checks++;
      if (k < STK) begin
        if (state !== 3'd1 || time_left !== 8'(STK - k)) begin
          errors++;
          $display("FAIL countdown_tick%0d: state=%0d tl=%0d, want 1/%0d",
                   k, state, time_left, STK - k);
        end
      end else begin
        if (state !== 3'd2 || time_left !== 8'(GT) || mole !== '0) begin
          errors++;
          $display("FAIL countdown_done: state=%0d tl=%0d mole=%b, want 2/%0d/0",
                   state, time_left, mole, GT);
        end
      end
    end
    step();
    checks++;
    if (state !== 3'd3 || !fresh_mole(mole) || score !== 8'd0) begin
      errors++;
      $display("FAIL first_mole: state=%0d mole=%b score=%0d prev=%b, want 3/onehot/0",
               state, mole, score, prev_mole);
    end
    prev_mole = mole;
    prev_known = 1'b1;
    m_score = 0;
    m_game = GT;
    m_mole = MT;
  endtask

  task automatic test_hit_and_penalty();
    int ops [6] = '{1, 0, 1, 0, 0, 2};
    for (int i = 0; i < 6; i++) begin
      if (ops[i] == 0) begin
        whack = mole;
        step();
        step();
        m_score = sat_inc(m_score);
        checks++;
        if (score !== 8'(m_score) || hit_pulse !== 1'b1 ||
            state !== 3'd2 || mole !== '0) begin
          errors++;
          $display("FAIL hit%0d: score=%0d hit=%b state=%0d mole=%b, want %0d/1/2/0",
                   i, score, hit_pulse, state, mole, m_score);
        end
        whack = '0;
        step();
        checks++;
        if (hit_pulse !== 1'b0 || state !== 3'd3 || !fresh_mole(mole)) begin
          errors++;
          $display("FAIL respawn%0d: hit=%b state=%0d mole=%b prev=%b",
                   i, hit_pulse, state, mole, prev_mole);
        end
        prev_mole = mole;
        m_mole = MT;
      end else begin
        whack = wrong_bit(mole);
        step();
        step();
        m_score = floor_dec(m_score);
        if (ops[i] == 2) repeat (5) step();
        checks++;
        if (score !== 8'(m_score) || state !== 3'd3 ||
            hit_pulse !== 1'b0 || mole !== prev_mole) begin
          errors++;
          $display("FAIL wrong%0d: score=%0d state=%0d hit=%b mole=%b, want %0d/3/0/%b",
                   i, score, state, hit_pulse, mole, m_score, prev_mole);
        end
        whack = '0;
        step();
      end
    end
  endtask

  task automatic test_miss_and_end();
    for (int i = 0; i < GT; i++) begin
      pulse_tick();
      m_game--;
      m_mole--;
      checks++;
      if (m_game == 0) begin
        if (state !== 3'd4 || game_over !== 1'b1 || mole !== '0 ||
            time_left !== 8'd0 || score !== 8'(m_score)) begin
          errors++;
          $display("FAIL game_end: state=%0d over=%b mole=%b tl=%0d score=%0d",
                   state, game_over, mole, time_left, score);
        end
      end else if (m_mole == 0) begin
        if (state !== 3'd2 || mole !== '0 ||
            time_left !== 8'(m_game) || score !== 8'(m_score)) begin
          errors++;
          $display("FAIL miss: state=%0d mole=%b tl=%0d score=%0d, want 2/0/%0d/%0d",
                   state, mole, time_left, score, m_game, m_score);
        end
        step();
        checks++;
        if (state !== 3'd3 || !fresh_mole(mole)) begin
          errors++;
          $display("FAIL miss_respawn: state=%0d mole=%b prev=%b",
                   state, mole, prev_mole);
        end
        prev_mole = mole;
        m_mole = MT;
      end else begin
        if (state !== 3'd3 || mole !== prev_mole ||
            time_left !== 8'(m_game)) begin
          errors++;
          $display("FAIL tick_active: state=%0d mole=%b tl=%0d, want 3/%b/%0d",
                   state, mole, time_left, prev_mole, m_game);
        end
      end
    end
    pulse_tick();
    checks++;
    if (state !== 3'd4 || time_left !== 8'd0) begin
      errors++;
      $display("FAIL over_tick: state=%0d tl=%0d, want 4/0", state, time_left);
    end
  endtask

  task automatic test_restart_from_over();
    pulse_start();
    checks++;
    if (state !== 3'd1 || time_left !== 8'(STK) ||
        score !== 8'd0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart: state=%0d tl=%0d score=%0d over=%b, want 1/%0d/0/0",
               state, time_left, score, game_over, STK);
    end
    repeat (STK) pulse_tick();
    step();
    checks++;
    if (state !== 3'd3 || time_left !== 8'(GT) || !fresh_mole(mole)) begin
      errors++;
      $display("FAIL restart_active: state=%0d tl=%0d mole=%b prev=%b",
               state, time_left, mole, prev_mole);
    end
    prev_mole = mole;
    prev_known = 1'b1;
    m_score = 0;
    m_game = GT;
    m_mole = MT;
  endtask

  task automatic test_hit_on_final_tick();
    for (int i = 0; i < GT; i++) begin
      whack = mole;
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      m_score = sat_inc(m_score);
      m_game--;
      checks++;
      if (m_game > 0) begin
        if (state !== 3'd2 || score !== 8'(m_score) ||
            time_left !== 8'(m_game) || hit_pulse !== 1'b1) begin
          errors++;
          $display("FAIL hit_tick%0d: state=%0d score=%0d tl=%0d hit=%b",
                   i, state, score, time_left, hit_pulse);
        end
        whack = '0;
        step();
        checks++;
        if (state !== 3'd3 || !fresh_mole(mole)) begin
          errors++;
          $display("FAIL hit_tick_respawn%0d: state=%0d mole=%b", i, state, mole);
        end
        prev_mole = mole;
        m_mole = MT;
      end else begin
        if (state !== 3'd4 || score !== 8'(m_score) || time_left !== 8'd0 ||
            game_over !== 1'b1 || hit_pulse !== 1'b1 || mole !== '0) begin
          errors++;
          $display("FAIL final_tick_hit: state=%0d score=%0d tl=%0d over=%b hit=%b mole=%b",
                   state, score, time_left, game_over, hit_pulse, mole);
        end
        whack = '0;
        step();
      end
    end
  endtask

  task automatic test_random_games();
    int a;
    bit done;
    for (int g = 0; g < 6; g++) begin
      pulse_start();
      checks++;
      if (state !== 3'd1 || score !== 8'd0) begin
        errors++;
        $display("FAIL rnd_start%0d: state=%0d score=%0d", g, state, score);
      end
      repeat (STK) pulse_tick();
      step();
      checks++;
      if (state !== 3'd3 || !fresh_mole(mole)) begin
        errors++;
        $display("FAIL rnd_first%0d: state=%0d mole=%b", g, state, mole);
      end
      prev_mole = mole;
      prev_known = 1'b1;
      m_score = 0;
      m_game = GT;
      m_mole = MT;
      done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
        a = $urandom_range(0, 5);
        case (a)
          0, 1: begin
            whack = mole;
            step();
            if (a == 1) tick = 1'b1;
            step();
            tick = 1'b0;
            m_score = sat_inc(m_score);
            if (a == 1) m_game--;
            checks++;
            if (score !== 8'(m_score) || time_left !== 8'(m_game) ||
                state !== ((m_game == 0) ? 3'd4 : 3'd2) ||
                hit_pulse !== 1'b1 || mole !== '0) begin
              errors++;
              $display("FAIL rnd_hit: a=%0d state=%0d score=%0d tl=%0d hit=%b, want score %0d tl %0d",
                       a, state, score, time_left, hit_pulse, m_score, m_game);
            end
            whack = '0;
            step();
            if (m_game == 0) begin
              done = 1'b1;
            end else begin
              checks++;
              if (state !== 3'd3 || !fresh_mole(mole)) begin
                errors++;
                $display("FAIL rnd_hit_respawn: state=%0d mole=%b", state, mole);
              end
              prev_mole = mole;
              m_mole = MT;
            end
          end
          2: begin
            whack = wrong_bit(mole);
            step();
            step();
            m_score = floor_dec(m_score);
            checks++;
            if (score !== 8'(m_score) || state !== 3'd3 || mole !== prev_mole) begin
              errors++;
              $display("FAIL rnd_wrong: score=%0d state=%0d mole=%b, want %0d/3/%b",
                       score, state, mole, m_score, prev_mole);
            end
            whack = '0;
            step();
          end
          3: begin
            pulse_tick();
            m_game--;
            m_mole--;
            checks++;
            if (m_game == 0) begin
              if (state !== 3'd4 || mole !== '0 || time_left !== 8'd0 ||
                  score !== 8'(m_score)) begin
                errors++;
                $display("FAIL rnd_end: state=%0d mole=%b tl=%0d score=%0d",
                         state, mole, time_left, score);
              end
              done = 1'b1;
            end else if (m_mole == 0) begin
              if (state !== 3'd2 || mole !== '0 || score !== 8'(m_score) ||
                  time_left !== 8'(m_game)) begin
                errors++;
                $display("FAIL rnd_miss: state=%0d mole=%b score=%0d tl=%0d",
                         state, mole, score, time_left);
              end
              step();
              checks++;
              if (state !== 3'd3 || !fresh_mole(mole)) begin
                errors++;
                $display("FAIL rnd_miss_respawn: state=%0d mole=%b", state, mole);
              end
              prev_mole = mole;
              m_mole = MT;
            end else begin
              if (state !== 3'd3 || mole !== prev_mole ||
                  time_left !== 8'(m_game)) begin
                errors++;
                $display("FAIL rnd_tick: state=%0d mole=%b tl=%0d, want 3/%b/%0d",
                         state, mole, time_left, prev_mole, m_game);
              end
            end
          end
          4: begin
            whack = mole;
            step();
            step();
            m_score = sat_inc(m_score);
            whack = '0;
            tick = 1'b1;
            step();
            tick = 1'b0;
            m_game--;
            checks++;
            if (m_game == 0) begin
              if (state !== 3'd4 || mole !== '0 || time_left !== 8'd0 ||
                  score !== 8'(m_score)) begin
                errors++;
                $display("FAIL rnd_spawn_end: state=%0d mole=%b tl=%0d score=%0d",
                         state, mole, time_left, score);
              end
              prev_known = 1'b0;
              done = 1'b1;
            end else begin
              if (state !== 3'd3 || time_left !== 8'(m_game) ||
                  score !== 8'(m_score) || !fresh_mole(mole)) begin
                errors++;
                $display("FAIL rnd_spawn_tick: state=%0d tl=%0d score=%0d mole=%b",
                         state, time_left, score, mole);
              end
              prev_mole = mole;
              m_mole = MT;
            end
          end
          default: begin
            pulse_start();
            checks++;
            if (state !== 3'd3 || score !== 8'(m_score) ||
                time_left !== 8'(m_game) || mole !== prev_mole) begin
              errors++;
              $display("FAIL rnd_start_ignored: state=%0d score=%0d tl=%0d mole=%b",
                       state, score, time_left, mole);
            end
          end
        endcase
      end
      checks++;
      if (!done || state !== 3'd4) begin
        errors++;
        $display("FAIL rnd_game%0d_end: done=%0d state=%0d, want over",
                 g, done, state);
      end
    end
  endtask

  task automatic test_score_saturation();
    pulse_start();
    repeat (STK) pulse_tick();
    step();
    prev_known = 1'b0;
    m_score = 0;
    for (int k = 1; k <= 257; k++) begin
      whack = mole;
      step();
      step();
      m_score = sat_inc(m_score);
      checks++;
      if (score !== 8'(m_score) || hit_pulse !== 1'b1) begin
        errors++;
        $display("FAIL sat_hit%0d: score=%0d hit=%b, want %0d/1",
                 k, score, hit_pulse, m_score);
      end
      whack = '0;
      step();
    end
    checks++;
    if (score !== 8'd255 || state !== 3'd3 || !$onehot(mole)) begin
      errors++;
      $display("FAIL sat_final: score=%0d state=%0d mole=%b, want 255/3/onehot",
               score, state, mole);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({state, mole, score, time_left, hit_pulse, game_over} !== '0) begin
      errors++;
      $display("FAIL async_reset: state=%0d mole=%b score=%0d tl=%0d hit=%b over=%b",
               state, mole, score, time_left, hit_pulse, game_over);
    end
    #2;
    rst = 1'b0;
    step();
    checks++;
    if (state !== 3'd0 || mole !== '0) begin
      errors++;
      $display("FAIL post_reset: state=%0d mole=%b, want 0/0", state, mole);
    end
    pulse_start();
    checks++;
    if (state !== 3'd1 || time_left !== 8'(STK)) begin
      errors++;
      $display("FAIL post_reset_start: state=%0d tl=%0d", state, time_left);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_hit_and_penalty();
    test_miss_and_end();
    test_restart_from_over();
    test_hit_on_final_tick();
    test_random_games();
    test_score_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
